multdiv_sequencer: RTL
======================

Name: multdiv_sequencer

Overview:
- Multi-cycle controller plus iterative datapath for the R-type mul/div ALU ops (opcode 5'b00000, ALUop 5'b00110 mul, 5'b00111 div).
- Accepts a one-cycle start pulse from decode/execute and holds the pipeline stalled while it iterates.
- Returns a 32-bit result, destination register tag and exception flag for writeback. Exception is routed to $rstatus by the writeback mux.
- Single shared unit: one operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start_mult  input  1  one-cycle request for signed multiply.
- start_div  input  1  one-cycle request for signed divide (quotient, truncated toward zero).
- operand_a  input  WIDTH  multiplicand / dividend; sampled on an accepted start.
- operand_b  input  WIDTH  multiplier / divisor; sampled on an accepted start.
- rd_in  input  5  destination register; sampled on an accepted start.
- stall  output  1  freeze PC and pipeline latches.
- busy  output  1  unit occupied (state != IDLE).
- result  output  WIDTH  product low word or quotient; valid only while result_valid=1.
- result_valid  output  1  one-cycle pulse; result, rd_out and exception are valid.
- rd_out  output  5  latched destination tag.
- exception  output  1  overflow (mult) or divide-by-zero (div); qualified by result_valid.

Behaviour:
- Reset (async, any state): state=IDLE. stall=0, busy=0, result=0, result_valid=0, rd_out=0, exception=0. Counter and internal registers cleared. An operation in flight is discarded with no result_valid.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - start_mult=1 → MUL.
  - else start_div=1 → DIV.
  - Both asserted together: mult wins, div is dropped.
  - On acceptance, latch |a|, |b|, result sign (a[MSB]^b[MSB]) and rd_in; clear counter.
- MUL: unsigned shift-add on magnitudes, one bit per cycle, into a 2*WIDTH accumulator. Exactly WIDTH cycles in MUL, then → DONE.
- DIV: restoring division on magnitudes, one quotient bit per cycle. Exactly WIDTH cycles in DIV, then → DONE.
  - Divisor==0 at acceptance: skip iteration; DIV lasts 1 cycle, then → DONE with result=0, exception=1.
- DONE:
  - Apply the sign to form the two's-complement result.
  - result_valid=1 for exactly this cycle, then → IDLE unconditionally.
- Mult overflow: exception=1 when the signed 2*WIDTH product's upper WIDTH+1 bits are not all equal. result is still the low WIDTH bits (0x7FFFFFFF*2 → result 0xFFFFFFFE, exception=1).
- Div special case: 0x80000000 / 0xFFFFFFFF → result 0x80000000, exception=0 (wraps).
- stall = accepted start (combinational, same cycle) OR state in {MUL, DIV}. stall=0 in DONE so the writeback latch captures the result on that edge.
- Latency, start edge to result_valid: WIDTH+1 cycles for mul/div (33 at default); 2 cycles for div-by-zero.
- Starts while busy=1 are ignored (pipeline is stalled, so none are expected). No queueing.
- All outputs are registered except stall.

Optional Feature:
- Macro: MULTDIV_EARLY_OUT_EN.
- Defined:
  - mult with either operand == 0 → MUL lasts 1 cycle, then DONE with result=0, exception=0.
  - div with dividend == 0 and divisor != 0 → same 1-cycle path.
  - Latency in these cases = 2 cycles.
- Undefined: these cases take the full WIDTH iterations; the result is identical.

Test Plan:
- start_mult, a=7, b=-3, rd_in=5 → stall high 33 cycles; result_valid on cycle 33 with result=0xFFFFFFEB, rd_out=5, exception=0.
- start_div, a=-100, b=7 → result=0xFFFFFFF2 (-14), exception=0, latency 33 cycles.
- start_div, a=42, b=0 → result_valid on cycle 2, result=0, exception=1.
- start_mult, a=0x7FFFFFFF, b=2 → result=0xFFFFFFFE, exception=1; then a=0x10000, b=0x8000 → result=0x80000000, exception=1.
- Reset asserted mid-MUL (cycle 10), released 2 cycles later → all outputs 0 immediately and no result_valid. Then start_mult 3*4 → result 12 after 33 cycles.
- Simultaneous start_mult and start_div with a=6, b=3 → result 18 (mult). With MULTDIV_EARLY_OUT_EN defined, start_mult a=0 → result_valid on cycle 2.

Source files
------------

// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - iterative signed mul/div sequencer with pipeline stall and writeback outputs
// Optional build macro: MULTDIV_EARLY_OUT_EN (one-cycle early out for zero operands)
module multdiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [4:0]       rd_in,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [4:0]       rd_out,
    output logic             exception
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_nxt;

    logic [2*WIDTH-1:0] prod, prod_nxt, prod_signed;
    logic [WIDTH-1:0]   operand, abs_a, abs_b, quot_signed, div_diff;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [CNT_W-1:0]   cnt;
    logic               neg, skip, skip_exc, accept, last, ovf;
    logic               early_mul, early_div;

    assign abs_a = operand_a[WIDTH-1] ? (~operand_a + 1'b1) : operand_a;
    assign abs_b = operand_b[WIDTH-1] ? (~operand_b + 1'b1) : operand_b;

`ifdef MULTDIV_EARLY_OUT_EN
    assign early_mul = (operand_a == '0) || (operand_b == '0);
    assign early_div = (operand_a == '0) && (operand_b != '0);
`else
    assign early_mul = 1'b0;
    assign early_div = 1'b0;
`endif

    // prod holds {accumulator, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, operand} : '0);
        div_shift = prod[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift[WIDTH-1:0] - operand;
        prod_nxt  = prod;
        if (state == MUL) begin
            prod_nxt = {mul_sum, prod[WIDTH-1:1]};
        end else if (state == DIV) begin
            if (div_shift >= {1'b0, operand})
                prod_nxt = {div_diff, prod[WIDTH-2:0], 1'b1};
            else
                prod_nxt = {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
        end
        prod_signed = neg ? (~prod_nxt + 1'b1) : prod_nxt;
        quot_signed = neg ? (~prod_nxt[WIDTH-1:0] + 1'b1) : prod_nxt[WIDTH-1:0];
        ovf = !((&prod_signed[2*WIDTH-1:WIDTH-1]) || !(|prod_signed[2*WIDTH-1:WIDTH-1]));
    end

    assign last   = skip || (cnt == CNT_W'(WIDTH - 1));
    assign accept = (state == IDLE) && (start_mult || start_div);
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (start_mult)     state_nxt = MUL;
                else if (start_div) state_nxt = DIV;
            end
            MUL, DIV: begin
                stall = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            prod         <= '0;
            operand      <= '0;
            cnt          <= '0;
            neg          <= 1'b0;
            skip         <= 1'b0;
            skip_exc     <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            rd_out       <= '0;
            exception    <= 1'b0;
        end else begin
            state        <= state_nxt;
            result_valid <= 1'b0;
            if (accept) begin
                cnt    <= '0;
                rd_out <= rd_in;
                neg    <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                if (start_mult) begin
                    operand  <= abs_a;
                    prod     <= {{WIDTH{1'b0}}, abs_b};
                    skip     <= early_mul;
                    skip_exc <= 1'b0;
                end else begin
                    operand  <= abs_b;
                    prod     <= {{WIDTH{1'b0}}, abs_a};
                    skip     <= early_div || (operand_b == '0);
                    skip_exc <= (operand_b == '0);
                end
            end else if (state == MUL || state == DIV) begin
                prod <= prod_nxt;
                cnt  <= cnt + 1'b1;
                // The final iteration's result is signed and registered on the edge into DONE
                if (last) begin
                    result_valid <= 1'b1;
                    if (skip) begin
                        result    <= '0;
                        exception <= skip_exc;
                    end else if (state == MUL) begin
                        result    <= prod_signed[WIDTH-1:0];
                        exception <= ovf;
                    end else begin
                        result    <= quot_signed;
                        exception <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
